// File: rtl/csla_pkg.sv
// rtl/csla_pkg.sv - parameter checks and derived constants for the pipelined carry-select adder
package csla_pkg;

  // Number of carry-select blocks across the operand width.
  function automatic int csla_num_blocks(input int width, input int block);
    return width / block;
  endfunction

  // Number of pipeline stages, which is also the latency in enabled edges.
  function automatic int csla_num_stages(input int num_blocks, input int bps);
    return num_blocks / bps;
  endfunction

  // Operand bits consumed by one stage.
  function automatic int csla_stage_bits(input int block, input int bps);
    return block * bps;
  endfunction

  // Bit offset of the lowest bit evaluated by a given stage.
  function automatic int csla_stage_lsb(input int stage, input int block, input int bps);
    return stage * block * bps;
  endfunction

  // True when the width splits evenly into blocks and the blocks into at least one stage.
  function automatic bit csla_params_ok(input int width, input int block, input int bps);
    if (width < 1 || block < 1 || bps < 1) return 1'b0;
    if (width % block != 0) return 1'b0;
    if ((width / block) % bps != 0) return 1'b0;
    return ((width / block) / bps) >= 1;
  endfunction

endpackage

// File: rtl/csla_block.sv
// rtl/csla_block.sv - one carry-select block: both carry-in cases precomputed, selected late
module csla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             sel_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             cout_o,
  output logic             ctop_o
);

  logic [BLOCK:0] res0;
  logic [BLOCK:0] res1;

  // Both candidates are ready before the incoming carry arrives; only the mux is on the carry path.
  assign res0 = {1'b0, a_i} + {1'b0, b_i};
  assign res1 = {1'b0, a_i} + {1'b0, b_i} + {{BLOCK{1'b0}}, 1'b1};

  assign {cout_o, sum_o} = sel_i ? res1 : res0;

  // Carry into the top bit recovered from that bit's sum and operands.
  assign ctop_o = sum_o[BLOCK-1] ^ a_i[BLOCK-1] ^ b_i[BLOCK-1];

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// rtl/pipelined_carry_select_adder.sv - pipelined carry-select adder/subtractor with valid/ready handshake
module pipelined_carry_select_adder
  import csla_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int BLOCK            = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NB  = csla_num_blocks(WIDTH, BLOCK);
  localparam int L   = csla_num_stages(NB, BLOCKS_PER_STAGE);
  localparam int SB  = csla_stage_bits(BLOCK, BLOCKS_PER_STAGE);
  localparam int BPS = BLOCKS_PER_STAGE;

  if (!csla_params_ok(WIDTH, BLOCK, BLOCKS_PER_STAGE)) begin : g_param_check
    $error("pipelined_carry_select_adder: WIDTH, BLOCK and BLOCKS_PER_STAGE do not divide evenly");
  end

  logic             enable;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             msb_cin;

  // Whole pipeline moves together; it only stalls when a finished result is not being taken.
  assign enable   = !out_valid || out_ready;
  assign in_ready = enable;

  // Subtraction is a + ~b + 1, so the carry-in is forced high.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int LO_W = csla_stage_lsb(s, BLOCK, BPS);
    localparam int IN_W = WIDTH - LO_W;

    logic [IN_W-1:0]    src_a;
    logic [IN_W-1:0]    src_b;
    logic               src_c;
    logic               src_v;
    logic [BPS:0]       cc;
    logic [SB-1:0]      bsum;
    logic [LO_W+SB-1:0] sum_d;

    if (s == 0) begin : g_src_in
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = cin_eff;
      assign src_v = in_valid;
      assign sum_d = bsum;
    end else begin : g_src_prev
      assign src_a = g_stage[s-1].g_mid.a_q;
      assign src_b = g_stage[s-1].g_mid.b_q;
      assign src_c = g_stage[s-1].g_mid.c_q;
      assign src_v = g_stage[s-1].g_mid.v_q;
      assign sum_d = {bsum, g_stage[s-1].g_mid.sum_q};
    end

    assign cc[0] = src_c;

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      localparam int  K      = s * BPS + j;
      localparam bit  IS_MSB = (s == L - 1) && (j == BPS - 1);

      logic [BLOCK-1:0] blk_a;
      logic [BLOCK-1:0] blk_b;

      assign blk_a = src_a[j*BLOCK +: BLOCK];
      assign blk_b = src_b[j*BLOCK +: BLOCK];

      if (K == 0) begin : g_ripple
        logic [BLOCK:0] res;
        assign res = {1'b0, blk_a} + {1'b0, blk_b} + {{BLOCK{1'b0}}, cc[j]};
        assign bsum[j*BLOCK +: BLOCK] = res[BLOCK-1:0];
        assign cc[j+1] = res[BLOCK];
        if (IS_MSB) begin : g_msb
          assign msb_cin = res[BLOCK-1] ^ blk_a[BLOCK-1] ^ blk_b[BLOCK-1];
        end
      end else if (IS_MSB) begin : g_sel_msb
        csla_block #(.BLOCK(BLOCK)) u_blk (
          .a_i    (blk_a),
          .b_i    (blk_b),
          .sel_i  (cc[j]),
          .sum_o  (bsum[j*BLOCK +: BLOCK]),
          .cout_o (cc[j+1]),
          .ctop_o (msb_cin)
        );
      end else begin : g_sel
        logic ctop_unused;
        csla_block #(.BLOCK(BLOCK)) u_blk (
          .a_i    (blk_a),
          .b_i    (blk_b),
          .sel_i  (cc[j]),
          .sum_o  (bsum[j*BLOCK +: BLOCK]),
          .cout_o (cc[j+1]),
          .ctop_o (ctop_unused)
        );
      end
    end

    if (s < L - 1) begin : g_mid
      logic [IN_W-SB-1:0]  a_q;
      logic [IN_W-SB-1:0]  b_q;
      logic [LO_W+SB-1:0]  sum_q;
      logic                c_q;
      logic                v_q;

      // Intermediate stage: keep finished low sum bits, forward the operand bits still to add.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
          c_q   <= 1'b0;
          v_q   <= 1'b0;
        end else if (enable) begin
          a_q   <= src_a[IN_W-1:SB];
          b_q   <= src_b[IN_W-1:SB];
          sum_q <= sum_d;
          c_q   <= cc[BPS];
          v_q   <= src_v;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] sum_q;
      logic             c_q;
      logic             ctop_q;
      logic             v_q;

      // Final stage: holds the complete result presented on the outputs.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sum_q  <= '0;
          c_q    <= 1'b0;
          ctop_q <= 1'b0;
          v_q    <= 1'b0;
        end else if (enable) begin
          sum_q  <= sum_d;
          c_q    <= cc[BPS];
          ctop_q <= msb_cin;
          v_q    <= src_v;
        end
      end
    end
  end

  assign out_valid = g_stage[L-1].g_last.v_q;
  assign sum       = g_stage[L-1].g_last.sum_q;
  assign cout      = g_stage[L-1].g_last.c_q;
  assign ovf       = g_stage[L-1].g_last.c_q ^ g_stage[L-1].g_last.ctop_q;

endmodule
